// File: rtl/dac_sched_pkg.sv
// dac_sched_pkg
// Shared types and constants for the DAC frame scheduler and its FIFO.
//   state_e        : scheduler FSM states
//   frame_t        : one frame of four 8-bit channels, ch0 in the low byte
//   POWERUP_CYCLES : cycles of power-up before the first tick is honoured
//   ACK_TIMEOUT    : cycles the writer may keep ready high after a start
package dac_sched_pkg;

    typedef enum logic [2:0] {
        OFF,
        POWERUP,
        WAIT_TICK,
        ISSUE,
        ACK
    } state_e;

    localparam int POWERUP_CYCLES = 4;
    localparam int ACK_TIMEOUT    = 8;

    // Shared cycle counter width; must hold both POWERUP_CYCLES-1 and ACK_TIMEOUT-1.
    localparam int TIMER_W = 3;

    typedef struct packed {
        logic [7:0] ch3;
        logic [7:0] ch2;
        logic [7:0] ch1;
        logic [7:0] ch0;
    } frame_t;

endpackage

// File: rtl/frame_fifo.sv
// frame_fifo
// Synchronous frame FIFO, depth 2**AW, with registered level/full and a
// registered read port that only updates on a pop.
//   clk, resetn    : clock, asynchronous active-low reset
//   push_i/data_i  : push one frame (ignored when full or flushing)
//   pop_i          : pop head frame into pop_data_o (ignored when empty or flushing)
//   flush_i        : synchronous empty; wins over push and pop
//   pop_data_o     : last popped frame, held until the next pop
//   full_o/empty_o : status, derived from the registered level
//   level_o        : frames stored
import dac_sched_pkg::*;

module frame_fifo #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_i,
    input  frame_t        push_data_i,
    input  logic          pop_i,
    input  logic          flush_i,
    output frame_t        pop_data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   level_o
);

    localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

    frame_t          mem_q [0:(1<<AW)-1];
    frame_t          rd_data_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q, level_d;
    logic            full_q;
    logic            push_ok, pop_ok;

    assign push_ok = push_i && !full_q && !flush_i;
    assign pop_ok  = pop_i && (level_q != '0) && !flush_i;

    always_comb begin
        level_d = level_q;
        if (flush_i) begin
            level_d = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Storage array kept free of reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            full_q    <= 1'b0;
            rd_data_q <= '0;
        end else begin
            level_q <= level_d;
            full_q  <= (level_d == FULL_LEVEL);
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop_ok) begin
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    rd_data_q <= mem_q[rd_ptr_q];
                end
            end
        end
    end

    assign pop_data_o = rd_data_q;
    assign full_o     = full_q;
    assign empty_o    = (level_q == '0);
    assign level_o    = level_q;

endmodule

// File: rtl/dac_frame_scheduler.sv
// dac_frame_scheduler
// Buffers host frames, paces them with a rate divider and hands each one to
// the 4-channel DAC writer with a one-cycle start pulse gated by dac_ready.
// Inputs : clk, resetn (async, active low), wr_en/wr_data/flush (FIFO host side),
//          enable, rate_div, num_ch, err_clr, dac_ready
// Outputs: full, level, dac_start, dac_pwr, dac_num_ch, ch0..ch3,
//          underflow/late (pulses), wr_ovf/ack_err (sticky), underflow_cnt
// Optional: define DAC_SCHED_UNDERFLOW_CNT_EN to build the saturating
//           underflow counter; otherwise underflow_cnt is tied to 0.
import dac_sched_pkg::*;

module dac_frame_scheduler #(
    parameter int FIFO_AW = 3,
    parameter int DIV_W   = 16
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               wr_en,
    input  logic [31:0]        wr_data,
    input  logic               flush,
    output logic               full,
    output logic [FIFO_AW:0]   level,
    input  logic               enable,
    input  logic [DIV_W-1:0]   rate_div,
    input  logic [1:0]         num_ch,
    input  logic               err_clr,
    input  logic               dac_ready,
    output logic               dac_start,
    output logic               dac_pwr,
    output logic [1:0]         dac_num_ch,
    output logic [7:0]         ch0,
    output logic [7:0]         ch1,
    output logic [7:0]         ch2,
    output logic [7:0]         ch3,
    output logic               underflow,
    output logic               late,
    output logic               wr_ovf,
    output logic               ack_err,
    output logic [15:0]        underflow_cnt
);

    localparam logic [TIMER_W-1:0] PU_LAST  = TIMER_W'(POWERUP_CYCLES - 1);
    localparam logic [TIMER_W-1:0] ACK_LAST = TIMER_W'(ACK_TIMEOUT - 1);

    state_e               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 start_q, start_d;
    logic                 underflow_q, underflow_d;
    logic                 late_q, late_d;
    logic                 wr_ovf_q, wr_ovf_d;
    logic                 ack_err_q, ack_err_d;
    logic [1:0]           num_ch_q;
    logic                 div_run, tick, pop, ack_timeout;
    logic                 fifo_full, fifo_empty, fifo_avail;
    frame_t               fifo_frame;

    frame_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk         (clk),
        .resetn      (resetn),
        .push_i      (wr_en),
        .push_data_i (wr_data),
        .pop_i       (pop),
        .flush_i     (flush),
        .pop_data_o  (fifo_frame),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level)
    );

    // A frame being flushed this cycle is not available to the scheduler.
    assign fifo_avail = !fifo_empty && !flush;

    // Divider is frozen while powered down or powering up so the first tick
    // after power-up comes from wherever it was left.
    assign div_run = (state_q != OFF) && (state_q != POWERUP);
    assign tick    = div_run && (div_q == '0);

    always_comb begin
        div_d = div_q;
        if (div_run) div_d = tick ? rate_div : div_q - 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        start_d     = 1'b0;
        underflow_d = 1'b0;
        late_d      = 1'b0;
        pop         = 1'b0;
        ack_timeout = 1'b0;
        if (!enable) begin
            state_d = OFF;
            timer_d = '0;
        end else begin
            case (state_q)
                OFF: begin
                    state_d = POWERUP;
                    timer_d = '0;
                end
                POWERUP: begin
                    if (timer_q == PU_LAST) begin
                        state_d = WAIT_TICK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                WAIT_TICK: begin
                    if (tick) begin
                        if (fifo_avail) begin
                            pop     = 1'b1;
                            state_d = ISSUE;
                        end else begin
                            underflow_d = 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    late_d = tick;
                    if (dac_ready) begin
                        start_d = 1'b1;
                        state_d = ACK;
                        timer_d = '0;
                    end
                end
                ACK: begin
                    late_d = tick;
                    if (!dac_ready) begin
                        state_d = WAIT_TICK;
                    end else if (timer_q == ACK_LAST) begin
                        ack_timeout = 1'b1;
                        state_d     = WAIT_TICK;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: state_d = OFF;
            endcase
        end
    end

    // Sticky flags: a new fault in the same cycle as err_clr keeps the flag set.
    always_comb begin
        wr_ovf_d  = err_clr ? 1'b0 : wr_ovf_q;
        ack_err_d = err_clr ? 1'b0 : ack_err_q;
        if (wr_en && fifo_full && !flush) wr_ovf_d  = 1'b1;
        if (ack_timeout)                  ack_err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= OFF;
            timer_q     <= '0;
            div_q       <= '0;
            start_q     <= 1'b0;
            underflow_q <= 1'b0;
            late_q      <= 1'b0;
            wr_ovf_q    <= 1'b0;
            ack_err_q   <= 1'b0;
            num_ch_q    <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            div_q       <= div_d;
            start_q     <= start_d;
            underflow_q <= underflow_d;
            late_q      <= late_d;
            wr_ovf_q    <= wr_ovf_d;
            ack_err_q   <= ack_err_d;
            if (pop) num_ch_q <= num_ch;
        end
    end

`ifdef DAC_SCHED_UNDERFLOW_CNT_EN
    logic [15:0] uf_cnt_q, uf_cnt_d, uf_base;

    always_comb begin
        uf_base  = err_clr ? 16'h0000 : uf_cnt_q;
        uf_cnt_d = uf_base;
        if (underflow_d && (uf_base != 16'hFFFF)) uf_cnt_d = uf_base + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) uf_cnt_q <= '0;
        else         uf_cnt_q <= uf_cnt_d;
    end

    assign underflow_cnt = uf_cnt_q;
`else
    assign underflow_cnt = 16'h0000;
`endif

    assign full       = fifo_full;
    assign dac_start  = start_q;
    assign dac_pwr    = (state_q != OFF);
    assign dac_num_ch = num_ch_q;
    assign ch0        = fifo_frame.ch0;
    assign ch1        = fifo_frame.ch1;
    assign ch2        = fifo_frame.ch2;
    assign ch3        = fifo_frame.ch3;
    assign underflow  = underflow_q;
    assign late       = late_q;
    assign wr_ovf     = wr_ovf_q;
    assign ack_err    = ack_err_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// tb_dac_frame_scheduler
// Directed bench for dac_frame_scheduler: pacing, FIFO limits, late ticks,
// ack timeout, enable drop / re-enable and asynchronous reset.
module tb_dac_frame_scheduler;

    localparam int FIFO_AW = 3;
    localparam int DIV_W   = 16;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               wr_en = 1'b0;
    logic [31:0]        wr_data = '0;
    logic               flush = 1'b0;
    logic               enable = 1'b0;
    logic [DIV_W-1:0]   rate_div = '0;
    logic [1:0]         num_ch = '0;
    logic               err_clr = 1'b0;
    logic               dac_ready = 1'b0;
    logic               full, dac_start, dac_pwr, underflow, late, wr_ovf, ack_err;
    logic [FIFO_AW:0]   level;
    logic [1:0]         dac_num_ch;
    logic [7:0]         ch0, ch1, ch2, ch3;
    logic [15:0]        underflow_cnt;

    dac_frame_scheduler #(.FIFO_AW(FIFO_AW), .DIV_W(DIV_W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .flush         (flush),
        .full          (full),
        .level         (level),
        .enable        (enable),
        .rate_div      (rate_div),
        .num_ch        (num_ch),
        .err_clr       (err_clr),
        .dac_ready     (dac_ready),
        .dac_start     (dac_start),
        .dac_pwr       (dac_pwr),
        .dac_num_ch    (dac_num_ch),
        .ch0           (ch0),
        .ch1           (ch1),
        .ch2           (ch2),
        .ch3           (ch3),
        .underflow     (underflow),
        .late          (late),
        .wr_ovf        (wr_ovf),
        .ack_err       (ack_err),
        .underflow_cnt (underflow_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    int          late_cnt = 0;
    int          uf_cnt = 0;
    int          start_cyc[$];
    logic [31:0] start_frame[$];
    always @(negedge clk) begin
        if (dac_start) begin
            start_cyc.push_back(cyc);
            start_frame.push_back({ch3, ch2, ch1, ch0});
        end
        if (late)      late_cnt++;
        if (underflow) uf_cnt++;
    end

    // Writer model: 0 = drops ready for two cycles after each start,
    // 1 = ready held low, 2 = ready held high.
    int wmode = 0;
    int busy = 0;
    always @(posedge clk) begin
        #2;
        if (wmode == 1) begin
            busy = 0;
            dac_ready = 1'b0;
        end else if (wmode == 2) begin
            busy = 0;
            dac_ready = 1'b1;
        end else begin
            if (dac_start) busy = 2;
            else if (busy > 0) busy--;
            dac_ready = (busy == 0);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    function automatic int start_at(input int idx);
        if (idx < start_cyc.size()) return start_cyc[idx];
        return -1000;
    endfunction

    function automatic logic [31:0] frame_at(input int idx);
        if (idx < start_frame.size()) return start_frame[idx];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        enable = 1'b0;
        wr_en  = 1'b0;
        flush  = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    int k, k2, sb, lb, ub;
    logic [31:0] uf_cnt_exp;

    initial begin
        // ---- reset values + paced playback with underflow ----
        do_reset();
        check_eq("rst_start",   {31'd0, dac_start}, 32'd0);
        check_eq("rst_pwr",     {31'd0, dac_pwr}, 32'd0);
        check_eq("rst_full",    {31'd0, full}, 32'd0);
        check_eq("rst_level",   {28'd0, level}, 32'd0);
        check_eq("rst_ch",      {ch3, ch2, ch1, ch0}, 32'd0);
        check_eq("rst_flags",   {28'd0, wr_ovf, ack_err, underflow, late}, 32'd0);
        check_eq("rst_numch",   {30'd0, dac_num_ch}, 32'd0);
        check_eq("rst_ufcnt",   {16'd0, underflow_cnt}, 32'd0);

        rate_div = 16'd9;
        num_ch   = 2'd2;
        wmode    = 0;
        push(32'h44332211);
        push(32'h88776655);
        push(32'hCCBBAA99);
        check_eq("t1_level3", {28'd0, level}, 32'd3);
        sb = start_cyc.size();
        lb = late_cnt;
        ub = uf_cnt;
        enable = 1'b1;
        k = cyc;
        wait_until(k + 40);
        check_eq("t1_nstart",  start_cyc.size() - sb, 32'd3);
        check_eq("t1_lat1",    start_at(sb) - k, 32'd7);
        check_eq("t1_lat2",    start_at(sb + 1) - k, 32'd17);
        check_eq("t1_lat3",    start_at(sb + 2) - k, 32'd27);
        check_eq("t1_ch0_at1", frame_at(sb) & 32'hFF, 32'h11);
        check_eq("t1_frame2",  frame_at(sb + 1), 32'h88776655);
        check_eq("t1_uf",      uf_cnt - ub, 32'd1);
        check_eq("t1_late",    late_cnt - lb, 32'd0);
        check_eq("t1_chhold",  {ch3, ch2, ch1, ch0}, 32'hCCBBAA99);
        check_eq("t1_numch",   {30'd0, dac_num_ch}, 32'd2);
`ifdef DAC_SCHED_UNDERFLOW_CNT_EN
        uf_cnt_exp = 32'd1;
`else
        uf_cnt_exp = 32'd0;
`endif
        check_eq("t1_ufcnt",   {16'd0, underflow_cnt}, uf_cnt_exp);

        // ---- FIFO overflow and flush ----
        do_reset();
        for (int i = 0; i < 9; i++) begin
            push(32'h100 + i);
            if (i == 7) begin
                check_eq("t2_full8",  {31'd0, full}, 32'd1);
                check_eq("t2_level8", {28'd0, level}, 32'd8);
                check_eq("t2_noovf",  {31'd0, wr_ovf}, 32'd0);
            end
        end
        check_eq("t2_ovf",     {31'd0, wr_ovf}, 32'd1);
        check_eq("t2_level9",  {28'd0, level}, 32'd8);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'hDEAD0000;
        @(negedge clk);
        flush = 1'b0;
        wr_en = 1'b0;
        check_eq("t2_flushlv", {28'd0, level}, 32'd0);
        check_eq("t2_flushfl", {31'd0, full}, 32'd0);
        check_eq("t2_ovfkeep", {31'd0, wr_ovf}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t2_ovfclr",  {31'd0, wr_ovf}, 32'd0);

        // ---- writer stalls: late ticks in ISSUE, single start ----
        do_reset();
        rate_div = 16'd0;
        num_ch   = 2'd3;
        wmode    = 1;
        push(32'hDEADBEEF);
        sb = start_cyc.size();
        lb = late_cnt;
        enable = 1'b1;
        k = cyc;
        wait_until(k + 20);
        wmode = 0;
        wait_until(k + 30);
        check_eq("t3_nstart", start_cyc.size() - sb, 32'd1);
        check_eq("t3_lat",    start_at(sb) - k, 32'd22);
        check_eq("t3_late",   late_cnt - lb, 32'd17);
        check_eq("t3_ch",     {ch3, ch2, ch1, ch0}, 32'hDEADBEEF);
        check_eq("t3_numch",  {30'd0, dac_num_ch}, 32'd3);

        // ---- ready never drops: ack timeout ----
        do_reset();
        rate_div = 16'd99;
        wmode    = 2;
        push(32'h0A0B0C0D);
        sb = start_cyc.size();
        enable = 1'b1;
        k = cyc;
        wait_until(k + 14);
        check_eq("t4_noerr",  {31'd0, ack_err}, 32'd0);
        wait_until(k + 15);
        check_eq("t4_ackerr", {31'd0, ack_err}, 32'd1);
        check_eq("t4_lat",    start_at(sb) - k, 32'd7);
        check_eq("t4_nstart", start_cyc.size() - sb, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check_eq("t4_clr",    {31'd0, ack_err}, 32'd0);
        check_eq("t4_pwr",    {31'd0, dac_pwr}, 32'd1);

        // ---- enable dropped in ACK, then re-enable ----
        do_reset();
        rate_div = 16'd0;
        wmode    = 2;
        push(32'h11111111);
        push(32'h22222222);
        sb = start_cyc.size();
        enable = 1'b1;
        k = cyc;
        wait_until(k + 8);
        check_eq("t5_pwr_on", {31'd0, dac_pwr}, 32'd1);
        check_eq("t5_start1", start_at(sb) - k, 32'd7);
        enable = 1'b0;
        wait_until(k + 9);
        check_eq("t5_pwr_off", {31'd0, dac_pwr}, 32'd0);
        check_eq("t5_nostart", {31'd0, dac_start}, 32'd0);
        wmode = 0;
        wait_until(k + 12);
        check_eq("t5_lvkeep", {28'd0, level}, 32'd1);
        check_eq("t5_chkeep", {ch3, ch2, ch1, ch0}, 32'h11111111);
        enable = 1'b1;
        k2 = cyc;
        wait_until(k2 + 10);
        check_eq("t5_nstart", start_cyc.size() - sb, 32'd2);
        check_eq("t5_relat",  start_at(sb + 1) - k2, 32'd7);
        check_eq("t5_frame2", frame_at(sb + 1), 32'h22222222);
        check_eq("t5_noerr",  {31'd0, ack_err}, 32'd0);

        // ---- asynchronous reset while in ISSUE ----
        do_reset();
        rate_div = 16'd0;
        num_ch   = 2'd1;
        wmode    = 1;
        push(32'h55AA55AA);
        push(32'h66BB66BB);
        enable = 1'b1;
        k = cyc;
        wait_until(k + 10);
        check_eq("t6_pwr",    {31'd0, dac_pwr}, 32'd1);
        check_eq("t6_level",  {28'd0, level}, 32'd1);
        check_eq("t6_late",   {31'd0, late}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("t6_ar_pwr",   {31'd0, dac_pwr}, 32'd0);
        check_eq("t6_ar_level", {28'd0, level}, 32'd0);
        check_eq("t6_ar_ch",    {ch3, ch2, ch1, ch0}, 32'd0);
        check_eq("t6_ar_numch", {30'd0, dac_num_ch}, 32'd0);
        check_eq("t6_ar_late",  {31'd0, late}, 32'd0);
        enable = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check_eq("t6_off",      {31'd0, dac_pwr}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
